// File: rtl/colisao_municao_nave.sv
// rtl/colisao_municao_nave.sv - enemy bullet vs player ship collision, lives, invulnerability window.
// Optional HUD life icons on R/G/B when HUD_RGB_EN is defined; otherwise R/G/B are tied to zero.
module colisao_municao_nave #(
    parameter int BULLET_W      = 1,
    parameter int BULLET_H      = 20,
    parameter int SHIP_W        = 40,
    parameter int SHIP_H        = 30,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_CYCLES = 50_000_000,
    parameter int BLINK_BIT     = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] posX_municao,
    input  logic [10:0] posY_municao,
    input  logic [10:0] posX_nave,
    input  logic [10:0] posY_nave,
    input  logic        restart,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic [2:0]  vidas,
    output logic        hit_pulse,
    output logic        invulneravel,
    output logic        blink,
    output logic        game_over,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    localparam int CNT_W_MIN = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam int CNT_W     = (CNT_W_MIN > BLINK_BIT) ? CNT_W_MIN : BLINK_BIT + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [2:0]       LIVES_RST = 3'(LIVES_INIT);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_INVULN    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         vidas_q, vidas_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               overlap_q, overlap_d;
    logic               overlap_now;

    // Widen to 12 bits so right/bottom edges near 2047 do not wrap.
    logic [11:0] bx, by, sx, sy;
    assign bx = {1'b0, posX_municao};
    assign by = {1'b0, posY_municao};
    assign sx = {1'b0, posX_nave};
    assign sy = {1'b0, posY_nave};

    assign overlap_now = (posY_municao != 11'd0)
                      && (bx < sx + 12'(SHIP_W))   && (sx < bx + 12'(BULLET_W))
                      && (by < sy + 12'(SHIP_H))   && (sy < by + 12'(BULLET_H));

    // Overlap seen while invulnerable is dropped, so a bullet still touching at exit
    // is re-sampled fresh once ALIVE resumes.
    assign overlap_d = overlap_now && (state_q != ST_INVULN);

    always_comb begin
        state_d = state_q;
        vidas_d = vidas_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        if (restart) begin
            state_d = ST_ALIVE;
            vidas_d = LIVES_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (overlap_q) begin
                        hit_d = 1'b1;
                        cnt_d = '0;
                        if (vidas_q > 3'd1) begin
                            state_d = ST_INVULN;
                            vidas_d = vidas_q - 3'd1;
                        end else begin
                            state_d = ST_GAME_OVER;
                            vidas_d = 3'd0;
                        end
                    end
                end
                ST_INVULN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    vidas_d = 3'd0;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ALIVE;
            vidas_q   <= LIVES_RST;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vidas_q   <= vidas_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            overlap_q <= overlap_d;
        end
    end

    assign vidas        = vidas_q;
    assign hit_pulse    = hit_q;
    assign invulneravel = (state_q == ST_INVULN);
    assign game_over    = (state_q == ST_GAME_OVER);
    assign blink        = (state_q == ST_INVULN) && cnt_q[BLINK_BIT];

`ifdef HUD_RGB_EN
    logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       icon_on, row_on, blank;

    always_comb begin
        r_d     = 8'd0;
        g_d     = 8'd0;
        b_d     = 8'd0;
        icon_on = 1'b0;
        blank   = (v_counter <= 10'd2) || (h_counter <= 10'd96);
        row_on  = (v_counter >= 10'd10) && (v_counter < 10'd18);
        // Icons on a 12-pixel pitch, 8 pixels wide, one per remaining life.
        for (int i = 0; i < 7; i++) begin
            if ((3'(i) < vidas_q) && (h_counter >= 10'(100 + 12*i))
                && (h_counter < 10'(108 + 12*i))) begin
                icon_on = 1'b1;
            end
        end
        if (!blank && row_on) begin
            if (state_q == ST_GAME_OVER) begin
                if ((h_counter >= 10'd100) && (h_counter < 10'd184)) begin
                    r_d = 8'hFF;
                end
            end else if (icon_on) begin
                g_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 8'd0;
            g_q <= 8'd0;
            b_q <= 8'd0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign R = r_q;
    assign G = g_q;
    assign B = b_q;
`else
    logic unused_hud;
    assign unused_hud = ^{h_counter, v_counter};
    assign R = 8'd0;
    assign G = 8'd0;
    assign B = 8'd0;
`endif

endmodule

// File: tb/tb_colisao_municao_nave.sv
// tb/tb_colisao_municao_nave.sv - directed self-checking bench for colisao_municao_nave.
module tb_colisao_municao_nave;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [10:0] posX_municao, posY_municao, posX_nave, posY_nave;
    logic [9:0]  h_counter, v_counter;
    logic [2:0]  vidas;
    logic        hit_pulse, invulneravel, blink, game_over;
    logic [7:0]  R, G, B;

    int errors = 0;
    int checks = 0;

    colisao_municao_nave #(
        .INVULN_CYCLES (16),
        .BLINK_BIT     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .posX_municao (posX_municao),
        .posY_municao (posY_municao),
        .posX_nave    (posX_nave),
        .posY_nave    (posY_nave),
        .restart      (restart),
        .h_counter    (h_counter),
        .v_counter    (v_counter),
        .vidas        (vidas),
        .hit_pulse    (hit_pulse),
        .invulneravel (invulneravel),
        .blink        (blink),
        .game_over    (game_over),
        .R            (R),
        .G            (G),
        .B            (B)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pos(input int bx, input int by, input int sx, input int sy);
        posX_municao = 11'(bx);
        posY_municao = 11'(by);
        posX_nave    = 11'(sx);
        posY_nave    = 11'(sy);
    endtask

    task automatic do_restart;
        set_pos(200, 0, 300, 400);
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset;
        int hits;
        reset = 1'b1; restart = 1'b0;
        h_counter = 10'd0; v_counter = 10'd0;
        set_pos(200, 100, 300, 400);
        repeat (3) @(negedge clk);
        checks++; if (vidas !== 3'd3) begin errors++; $display("FAIL reset_vidas: got %0d expected 3", vidas); end
        checks++; if ({hit_pulse, invulneravel, blink, game_over} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {hit_pulse, invulneravel, blink, game_over}); end
        checks++; if ({R, G, B} !== 24'd0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", {R, G, B}); end
        reset = 1'b0;
        hits = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (hit_pulse) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL idle_hits: got %0d expected 0", hits); end
        checks++; if (vidas !== 3'd3) begin errors++; $display("FAIL idle_vidas: got %0d expected 3", vidas); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL idle_game_over: got %b expected 0", game_over); end
    endtask

    task automatic test_single_hit;
        set_pos(310, 395, 300, 400);
        tick();
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_latency1: got %b expected 0", hit_pulse); end
        set_pos(200, 100, 300, 400);
        tick();
        checks++; if (vidas !== 3'd2) begin errors++; $display("FAIL hit_vidas: got %0d expected 2", vidas); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (hit_pulse !== (k == 0)) begin errors++; $display("FAIL hit_pulse_k%0d: got %b expected %b", k, hit_pulse, (k == 0)); end
            checks++; if (invulneravel !== 1'b1) begin errors++; $display("FAIL invuln_k%0d: got %b expected 1", k, invulneravel); end
            checks++; if (blink !== ((k >> 2) & 1)) begin errors++; $display("FAIL blink_k%0d: got %b expected %0d", k, blink, (k >> 2) & 1); end
            tick();
        end
        checks++; if (invulneravel !== 1'b0) begin errors++; $display("FAIL invuln_exit: got %b expected 0", invulneravel); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_exit: got %b expected 0", blink); end
    endtask

    task automatic test_back_to_back;
        logic exp_hit;
        do_restart();
        checks++; if (vidas !== 3'd3) begin errors++; $display("FAIL b2b_start_vidas: got %0d expected 3", vidas); end
        set_pos(310, 395, 300, 400);
        for (int k = 1; k <= 80; k++) begin
            tick();
            exp_hit = (k == 2) || (k == 20) || (k == 38);
            checks++; if (hit_pulse !== exp_hit) begin errors++; $display("FAIL b2b_hit_k%0d: got %b expected %b", k, hit_pulse, exp_hit); end
            if (k == 2) begin
                checks++; if (vidas !== 3'd2) begin errors++; $display("FAIL b2b_vidas1: got %0d expected 2", vidas); end
            end
            if (k == 20) begin
                checks++; if (vidas !== 3'd1) begin errors++; $display("FAIL b2b_vidas2: got %0d expected 1", vidas); end
            end
            if (k == 37) begin
                checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL b2b_go_early: got %b expected 0", game_over); end
            end
            if (k == 38) begin
                checks++; if ({game_over, vidas} !== {1'b1, 3'd0}) begin errors++; $display("FAIL b2b_go: got go=%b vidas=%0d expected go=1 vidas=0", game_over, vidas); end
            end
        end
        checks++; if ({game_over, vidas, invulneravel} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL b2b_end: got go=%b vidas=%0d inv=%b expected go=1 vidas=0 inv=0", game_over, vidas, invulneravel); end
    endtask

    task automatic test_restart_game_over;
        set_pos(200, 0, 300, 400);
        h_counter = 10'd101; v_counter = 10'd11;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if ({game_over, invulneravel, hit_pulse} !== 3'b000) begin errors++; $display("FAIL rst_go_flags: got %b expected 000", {game_over, invulneravel, hit_pulse}); end
        checks++; if (vidas !== 3'd3) begin errors++; $display("FAIL rst_go_vidas: got %0d expected 3", vidas); end
`ifdef HUD_RGB_EN
        checks++; if ({R, G, B} !== 24'hFF0000) begin errors++; $display("FAIL hud_red: got %h expected ff0000", {R, G, B}); end
`else
        checks++; if ({R, G, B} !== 24'd0) begin errors++; $display("FAIL hud_off1: got %h expected 000000", {R, G, B}); end
`endif
        tick();
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL rst_go_nohit: got %b expected 0", hit_pulse); end
`ifdef HUD_RGB_EN
        checks++; if ({R, G, B} !== 24'h00FF00) begin errors++; $display("FAIL hud_green: got %h expected 00ff00", {R, G, B}); end
`else
        checks++; if ({R, G, B} !== 24'd0) begin errors++; $display("FAIL hud_off2: got %h expected 000000", {R, G, B}); end
`endif
        h_counter = 10'd0; v_counter = 10'd0;
    endtask

    task automatic test_restart_in_alive;
        set_pos(310, 395, 300, 400);
        tick();
        restart = 1'b1;
        set_pos(200, 0, 300, 400);
        tick();
        restart = 1'b0;
        checks++; if ({hit_pulse, invulneravel, vidas} !== {2'b00, 3'd3}) begin errors++; $display("FAIL restart_beats_hit: got hit=%b inv=%b vidas=%0d expected 0 0 3", hit_pulse, invulneravel, vidas); end
        tick();
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL restart_after: got %b expected 0", hit_pulse); end
    endtask

    task automatic test_parked;
        int hits;
        set_pos(310, 0, 300, 5);
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (hit_pulse) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL parked_hits: got %0d expected 0", hits); end
        checks++; if (vidas !== 3'd3) begin errors++; $display("FAIL parked_vidas: got %0d expected 3", vidas); end
    endtask

    task automatic test_edges;
        int vec [9][5] = '{
            '{340, 395, 300, 400, 0},
            '{339, 395, 300, 400, 1},
            '{299, 395, 300, 400, 0},
            '{300, 395, 300, 400, 1},
            '{310, 380, 300, 400, 0},
            '{310, 381, 300, 400, 1},
            '{310, 430, 300, 400, 0},
            '{310, 429, 300, 400, 1},
            '{2045, 395, 2040, 400, 1}
        };
        int hits;
        for (int v = 0; v < 9; v++) begin
            do_restart();
            set_pos(vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
            tick();
            set_pos(200, 0, 300, 400);
            hits = 0;
            repeat (4) begin
                tick();
                if (hit_pulse) hits++;
            end
            checks++; if (hits !== vec[v][4]) begin errors++; $display("FAIL edge_v%0d_hits: got %0d expected %0d", v, hits, vec[v][4]); end
            checks++; if (vidas !== ((vec[v][4] != 0) ? 3'd2 : 3'd3)) begin errors++; $display("FAIL edge_v%0d_vidas: got %0d", v, vidas); end
        end
    endtask

    task automatic test_async_reset;
        do_restart();
        set_pos(310, 395, 300, 400);
        tick();
        set_pos(200, 0, 300, 400);
        tick();
        repeat (5) tick();
        checks++; if (invulneravel !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", invulneravel); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({invulneravel, blink, hit_pulse, vidas} !== {3'b000, 3'd3}) begin errors++; $display("FAIL areset_abort: got inv=%b blink=%b hit=%b vidas=%0d expected 0 0 0 3", invulneravel, blink, hit_pulse, vidas); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (invulneravel !== 1'b0) begin errors++; $display("FAIL areset_after: got %b expected 0", invulneravel); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_back_to_back();
        test_restart_game_over();
        test_restart_in_alive();
        test_parked();
        test_edges();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
